// File: rtl/fpu_int2float_if.sv
// Operand/result handshake bundle for the integer-to-float converter.
// The master side feeds integers and consumes packed floats; the slave side
// is the converter itself.
interface fpu_int2float_if;
    logic [31:0] int_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output int_in,
        output in_valid,
        input  in_ready,
        input  data_out,
        input  status_out,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  int_in,
        input  in_valid,
        output in_ready,
        output data_out,
        output status_out,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/fpu_int2float.sv
// Iterative 32-bit signed integer to FPU float converter.
// Output format {sign, exp[5:0], mant[24:0]}, bias 31, implicit leading one.
// Normalisation shifts one bit per cycle until the magnitude MSB is set.
// Build option: define FPU_I2F_ROUND_NEAREST_EN for round-to-nearest-even
// in PACK; otherwise the mantissa is truncated toward zero magnitude.
//
// state | meaning
// IDLE  | ready for an operand, in_ready high
// NORM  | shifting magnitude left until bit 31 is set (or zero detected)
// PACK  | assemble sign/exponent/mantissa and status
// DONE  | result held with out_valid high until out_ready
module fpu_int2float (
    input  logic            clock_i,
    input  logic            reset_i,
    fpu_int2float_if.slave  bus
);

    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;
    localparam int BIAS   = 31;

    localparam logic [3:0] ST_EXACT   = 4'b0001;
    localparam logic [3:0] ST_INEXACT = 4'b1111;

    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  shift_cnt_q, shift_cnt_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  status_q, status_d;

    logic [EXP_W-1:0]  pack_exp;
    logic [MANT_W-1:0] pack_mant;
    logic              pack_inexact;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            shift_cnt_q <= '0;
            data_q      <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            shift_cnt_q <= shift_cnt_d;
            data_q      <= data_d;
            status_q    <= status_d;
        end
    end

    // Exponent/mantissa assembly from the normalised magnitude
    always_comb begin
        // 62 - shift_cnt: an unshifted magnitude has its MSB at bit 31
        pack_exp     = EXP_W'(BIAS + 31) - EXP_W'(shift_cnt_q);
        pack_mant    = mag_q[30:6];
        pack_inexact = |mag_q[5:0];
`ifdef FPU_I2F_ROUND_NEAREST_EN
        // Mantissa carry-out wraps pack_mant to zero and bumps the exponent;
        // the magnitude never exceeds 2^31 so the exponent stays below 63.
        if (mag_q[5] && ((|mag_q[4:0]) || mag_q[6])) begin
            pack_mant = pack_mant + MANT_W'(1);
            if (&mag_q[30:6]) begin
                pack_exp = pack_exp + EXP_W'(1);
            end
        end
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        shift_cnt_d = shift_cnt_q;
        data_d      = data_q;
        status_d    = status_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d      = bus.int_in[31];
                    // Negating 0x80000000 wraps back to itself, which is the correct magnitude
                    mag_d       = bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;
                    shift_cnt_d = '0;
                    state_d     = NORM;
                end
            end
            NORM: begin
                if (mag_q == 32'd0) begin
                    data_d   = '0;
                    status_d = ST_EXACT;
                    state_d  = DONE;
                end else if (mag_q[31]) begin
                    state_d = PACK;
                end else begin
                    mag_d       = {mag_q[30:0], 1'b0};
                    shift_cnt_d = shift_cnt_q + 5'd1;
                end
            end
            PACK: begin
                data_d   = {sign_q, pack_exp, pack_mant};
                status_d = pack_inexact ? ST_INEXACT : ST_EXACT;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.data_out   = data_q;
    assign bus.status_out = status_q;

endmodule
